// File: rtl/instr_control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and writeback control.
// Optional macro INSTR_CTRL_BRANCH_EN turns opcode 11 (imm != 4'hF) into a BEQ instead of a NOP.
module instr_control_fsm #(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                imem_valid,
  input  logic [7:0]          imem_data,
  input  logic                alu_zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic                imem_req,
  output logic                read_reg1,
  output logic                read_reg2,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic [3:0]          mem_addr,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_STORE   = 2'b10;
  localparam logic [1:0] OP_SPECIAL = 2'b11;
  localparam logic [3:0] IMM_HALT   = 4'hF;

  state_t              state;
  state_t              next_state;
  logic [7:0]          ir;
  logic                ir_load;
  logic                decode_en;
  logic                branch_take;
  logic [PC_WIDTH-1:0] imm_sext;

  assign imm_sext = PC_WIDTH'($signed(mem_addr));

`ifndef INSTR_CTRL_BRANCH_EN
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  always_comb begin
    next_state  = state;
    ir_load     = 1'b0;
    decode_en   = 1'b0;
    branch_take = 1'b0;
    imem_req    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        if (ir[7:6] == OP_SPECIAL && ir[3:0] == IMM_HALT) begin
          next_state = S_HALT;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (alu_op)
          OP_ADD:   next_state = S_WB;
          OP_LOAD:  next_state = S_MEM;
          OP_STORE: next_state = S_MEM;
          default: begin
`ifdef INSTR_CTRL_BRANCH_EN
            branch_take = alu_zero;
`endif
            next_state = run ? S_FETCH : S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        if (alu_op == OP_LOAD) begin
          mem_read   = 1'b1;
          next_state = S_WB;
        end else begin
          mem_write  = (alu_op == OP_STORE);
          next_state = run ? S_FETCH : S_IDLE;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Branch offset is relative to the pc already advanced in DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      read_reg1 <= 1'b0;
      read_reg2 <= 1'b0;
      alu_op    <= 2'b00;
      mem_addr  <= 4'h0;
    end else begin
      if (ir_load) begin
        ir <= imem_data;
      end
      if (decode_en) begin
        pc        <= pc + PC_WIDTH'(1);
        read_reg1 <= ir[5];
        read_reg2 <= ir[4];
        alu_op    <= ir[7:6];
        mem_addr  <= ir[3:0];
      end else if (branch_take) begin
        pc <= pc + imm_sext;
      end
    end
  end

endmodule

// File: doc/instr_control_fsm.md
INSTR_CONTROL_FSM -- requirements
Module: instr_control_fsm

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, which sets the width of the program counter in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, which sets the PC value loaded at reset.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port run SHALL be an input, 1 bit: a level that starts execution from IDLE.
REQ-006 Port imem_valid SHALL be an input, 1 bit: instruction memory has valid data on imem_data this cycle.
REQ-007 Port imem_data SHALL be an input, 8 bits: the instruction word, with fields [7:6] opcode, [5] rs, [4] rt, [3:0] imm.
REQ-008 Port alu_zero SHALL be an input, 1 bit: ALU result-equals-zero flag, sampled in EXEC.
REQ-009 Port pc SHALL be an output, PC_WIDTH bits: the current fetch address.
REQ-010 Port imem_req SHALL be an output, 1 bit: the fetch request, held high for the whole FETCH state.
REQ-011 Port read_reg1 SHALL be an output, 1 bit: register-bank index taken from rs.
REQ-012 Port read_reg2 SHALL be an output, 1 bit: register-bank index taken from rt; it is also the write index.
REQ-013 Port reg_write SHALL be an output, 1 bit: a one-cycle pulse in WB that tells the register bank to store data_memory_out.
REQ-014 Port alu_op SHALL be an output, 2 bits: the latched opcode, driven to the ALU.
REQ-015 Port mem_read SHALL be an output, 1 bit: data-memory read strobe, asserted in MEM.
REQ-016 Port mem_write SHALL be an output, 1 bit: data-memory write strobe, asserted in MEM.
REQ-017 Port mem_addr SHALL be an output, 4 bits: the latched imm field.
REQ-018 Port halted SHALL be an output, 1 bit: high while the FSM is in HALT.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT, and exactly one SHALL be active at a time.
REQ-020 Transitions: IDLE->FETCH when run=1; FETCH waits until imem_valid=1, latches imem_data into the instruction register (IR), then goes to DECODE.
REQ-021 In DECODE the FSM SHALL set pc <= pc+1, wrapping modulo 2^PC_WIDTH, and drive read_reg1, read_reg2, alu_op and mem_addr from IR; these hold until the next DECODE.
REQ-022 Opcode 00 (ADD) SHALL follow FETCH->DECODE->EXEC->WB->FETCH, taking 4 cycles plus the imem wait.
REQ-023 Opcode 01 (LOAD) SHALL follow FETCH->DECODE->EXEC->MEM->WB->FETCH, with mem_read=1 in MEM only.
REQ-024 Opcode 10 (STORE) SHALL follow FETCH->DECODE->EXEC->MEM->FETCH, with mem_write=1 in MEM only and reg_write=0 throughout.
REQ-025 Opcode 11 with imm=4'hF (HALT) SHALL go DECODE->HALT; HALT is left only by reset.
REQ-026 reg_write SHALL be high for exactly one cycle per ADD or LOAD, and never high outside WB.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle.
REQ-028 If run drops after FETCH has been entered, the current instruction SHALL complete, and the FSM SHALL return to IDLE at the next FETCH entry while run=0.
REQ-029 imem_data SHALL be ignored while imem_valid=0, and imem_valid SHALL be ignored outside FETCH.

Reset
REQ-030 On reset=1, immediately and regardless of clk: state=IDLE, pc=RESET_PC, IR=0, and imem_req, reg_write, mem_read, mem_write and halted all 0.
REQ-031 read_reg1, read_reg2, alu_op and mem_addr SHALL reset to 0.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction, so that no reg_write or mem_write pulse occurs after reset asserts.
REQ-033 After reset deasserts, the FSM SHALL leave IDLE only on a rising edge with run=1.

Configuration
REQ-034 With macro INSTR_CTRL_BRANCH_EN defined, opcode 11 with imm!=4'hF SHALL be BEQ: EXEC samples alu_zero, and if it is 1 then pc <= pc + sign-extended imm (modulo 2^PC_WIDTH, relative to the already-incremented pc); the FSM then goes to FETCH.
REQ-035 Without INSTR_CTRL_BRANCH_EN, opcode 11 with imm!=4'hF SHALL be a NOP: DECODE->EXEC->FETCH, pc unchanged beyond the DECODE increment, and no strobes.
REQ-036 HALT decoding SHALL be identical with and without the macro.

Verification
REQ-037 Scenario: reset, run=1, imem returns 8'b00_0_1_0000 with imem_valid=1 -> one reg_write pulse 3 cycles after the FETCH edge, read_reg1=0, read_reg2=1, pc=1.
REQ-038 Scenario: LOAD 8'b01_0_1_0101 with imem_valid delayed by 3 cycles -> FETCH held 4 cycles, mem_read=1 for 1 cycle with mem_addr=5, then reg_write=1 for 1 cycle.
REQ-039 Scenario: STORE 8'b10_1_0_0011 -> mem_write=1 for 1 cycle with mem_addr=3 and reg_write never asserted; then HALT 8'hCF -> halted=1 and pc=2, and the state is unchanged for 20 further cycles.
REQ-040 Scenario: with the macro, pc=8'hFE and BEQ imm=4'h3 with alu_zero=1 -> pc=8'h02 (wrap); the same with alu_zero=0 -> pc=8'hFF.
REQ-041 Scenario: reset asserted during MEM of a STORE, between clock edges -> mem_write drops immediately, pc=RESET_PC, and halted=0.
